// File: rtl/traffic_request_input_pkg.sv
`default_nettype none
// ============================================================================
// traffic_pkg : shared button-channel constants for the TrafficWing blocks
// Rev 1.0
// ============================================================================
package traffic_pkg;

    localparam int N_BUTTONS_DEFAULT       = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 960000;

    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_W = 3;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_request_input_if.sv
`default_nettype none
// ============================================================================
// traffic_request_input_if : button pins, debounced levels and request handshake
// Rev 1.0
// ============================================================================
interface traffic_request_input_if
    import traffic_pkg::*;
#(
    parameter int N_BUTTONS = N_BUTTONS_DEFAULT
);

    logic [N_BUTTONS-1:0] btn_in;
    logic [N_BUTTONS-1:0] ack;
    logic [N_BUTTONS-1:0] btn_level;
    logic [N_BUTTONS-1:0] press_pulse;
    logic [N_BUTTONS-1:0] req;

    modport master (
        output btn_in,
        output ack,
        input  btn_level,
        input  press_pulse,
        input  req
    );

    modport slave (
        input  btn_in,
        input  ack,
        output btn_level,
        output press_pulse,
        output req
    );

endinterface : traffic_request_input_if
`default_nettype wire

// File: rtl/traffic_request_input_debounce_cell.sv
`default_nettype none
// ============================================================================
// debounce_cell : 2-FF synchronizer, counter debouncer and press-edge pulse
// Rev 1.0
// ============================================================================
module debounce_cell
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_raw_pressed;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // Polarity is normalised before the synchronizer so reset means "not pressed".
    assign w_raw_pressed = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= w_raw_pressed;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_sync2;
                r_pulse <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign btn_level   = r_level;
    assign press_pulse = r_pulse;

endmodule : debounce_cell
`default_nettype wire

// File: rtl/traffic_request_input.sv
`default_nettype none
// ============================================================================
// traffic_request_input : debounced, latched crossing requests for the sequencer
// Rev 1.0
// ============================================================================
module traffic_request_input
    import traffic_pkg::*;
#(
    parameter int N_BUTTONS       = N_BUTTONS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   sclk,
    input  logic                   rst_n,
    traffic_request_input_if.slave bus
);

    logic [N_BUTTONS-1:0] w_level;
    logic [N_BUTTONS-1:0] w_pulse;
    logic [N_BUTTONS-1:0] r_req;

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_cell (
            .sclk        (sclk),
            .rst_n       (rst_n),
            .btn_raw     (bus.btn_in[gi]),
            .btn_level   (w_level[gi]),
            .press_pulse (w_pulse[gi])
        );
    end

    // A fresh press outranks an ack landing in the same cycle.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= '0;
        end else begin
            r_req <= w_pulse | (r_req & ~bus.ack);
        end
    end

    assign bus.btn_level   = w_level;
    assign bus.press_pulse = w_pulse;
    assign bus.req         = r_req;

endmodule : traffic_request_input
`default_nettype wire

// File: tb/tb_traffic_request_input.sv
`default_nettype none
// ============================================================================
// tb_traffic_request_input : scoreboard bench with a window-based reference model
// Rev 1.0
// ============================================================================
module tb_traffic_request_input;
    import traffic_pkg::*;

    localparam int NB = N_BUTTONS_DEFAULT;
    localparam int DC = 8;
    localparam bit AL = 1'b1;

    logic sclk  = 1'b0;
    logic rst_n = 1'b0;

    traffic_request_input_if #(.N_BUTTONS(NB)) bus ();

    traffic_request_input #(
        .N_BUTTONS       (NB),
        .DEBOUNCE_CYCLES (DC),
        .BTN_ACTIVE_LOW  (AL)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [NB-1:0] level;
        logic [NB-1:0] pulse;
        logic [NB-1:0] req;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_model_pulses = 0;
    int   n_dut_pulses   = 0;

    // Reference: an input is accepted once the last DC synchronized samples all
    // disagree with the current level; samples reach the window two edges late.
    logic [NB-1:0] m_level = '0;
    logic [NB-1:0] m_pulse = '0;
    logic [NB-1:0] m_req   = '0;
    bit            cap_hist[NB][$];
    bit            s_hist[NB][$];

    function automatic void model_step(input bit clear, input logic [NB-1:0] pressed,
                                       input logic [NB-1:0] ackv);
        bit s;
        bit all_diff;
        if (clear) begin
            m_level = '0;
            m_pulse = '0;
            m_req   = '0;
            for (int ch = 0; ch < NB; ch++) begin
                cap_hist[ch].delete();
                s_hist[ch].delete();
            end
            return;
        end
        m_req   = m_pulse | (m_req & ~ackv);
        m_pulse = '0;
        for (int ch = 0; ch < NB; ch++) begin
            s = (cap_hist[ch].size() >= 2) ? cap_hist[ch][cap_hist[ch].size()-2] : 1'b0;
            cap_hist[ch].push_back(pressed[ch]);
            if (cap_hist[ch].size() > 2) void'(cap_hist[ch].pop_front());
            s_hist[ch].push_back(s);
            if (s_hist[ch].size() > DC) void'(s_hist[ch].pop_front());
            if (s_hist[ch].size() == DC) begin
                all_diff = 1'b1;
                foreach (s_hist[ch][i]) if (s_hist[ch][i] == m_level[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[ch] = s;
                    m_pulse[ch] = s;
                end
            end
        end
    endfunction

    // One clock of stimulus; the expectation pushed describes the outputs seen at
    // the following falling edge, so a mid-cycle async reset expects all zeros.
    task automatic step(input logic [NB-1:0] pressed, input logic [NB-1:0] ackv,
                        input bit async_rst);
        bus.btn_in = AL ? ~pressed : pressed;
        bus.ack    = ackv;
        @(posedge sclk);
        model_step(!rst_n || async_rst, pressed, ackv);
        n_model_pulses += $countones(m_pulse);
        sb_q.push_back('{level: m_level, pulse: m_pulse, req: m_req});
        if (async_rst) begin
            #3;
            rst_n = 1'b0;
        end else begin
            #2;
        end
    endtask

    task automatic hold(input int n, input logic [NB-1:0] pressed);
        repeat (n) step(pressed, '0, 1'b0);
    endtask

    // Monitor: every falling edge pops one expectation and compares it.
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge sclk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_dut_pulses += $countones(bus.press_pulse);
                checks++;
                if (bus.btn_level !== e.level) begin
                    errors++;
                    $display("FAIL btn_level t=%0t got=%b exp=%b", $time, bus.btn_level, e.level);
                end
                checks++;
                if (bus.press_pulse !== e.pulse) begin
                    errors++;
                    $display("FAIL press_pulse t=%0t got=%b exp=%b", $time, bus.press_pulse, e.pulse);
                end
                checks++;
                if (bus.req !== e.req) begin
                    errors++;
                    $display("FAIL req t=%0t got=%b exp=%b", $time, bus.req, e.req);
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : p_driver
        logic [NB-1:0] pressed;
        logic [NB-1:0] ackv;
        int            remain[NB];

        bus.btn_in = AL ? '1 : '0;
        bus.ack    = '0;
        hold(3, '0);
        rst_n = 1'b1;

        // Single press on north, then release.
        hold(14, 4'b0001 << DIR_N);
        hold(12, '0);

        // East bounces: 5 pressed, 1 released, 8 pressed.
        hold(5, 4'b0001 << DIR_E);
        hold(1, '0);
        hold(8, 4'b0001 << DIR_E);
        hold(4, 4'b0001 << DIR_E);
        hold(12, '0);

        // South request, ack, then a stray ack with no request pending.
        hold(14, 4'b0001 << DIR_S);
        hold(4, '0);
        step('0, 4'b0001 << DIR_S, 1'b0);
        hold(4, '0);
        step('0, 4'b0001 << DIR_S, 1'b0);
        hold(4, '0);

        // West: second press arrives together with an ack while req is set.
        hold(14, 4'b0001 << DIR_W);
        hold(12, '0);
        repeat (14) step(4'b0001 << DIR_W, m_pulse & (4'b0001 << DIR_W), 1'b0);
        hold(12, '0);

        // All four together, then release of all.
        hold(14, '1);
        hold(14, '0);

        // Async reset mid-debounce with req = 0101.
        step('0, '1, 1'b0);
        hold(14, 4'b0101);
        hold(12, '0);
        hold(6, '1);
        step('1, '0, 1'b1);
        hold(2, '1);
        rst_n = 1'b1;
        hold(14, '1);
        hold(14, '0);

        // Randomised presses of random hold length with random acks.
        pressed = '0;
        for (int ch = 0; ch < NB; ch++) remain[ch] = $urandom_range(1, 14);
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int ch = 0; ch < NB; ch++) begin
                remain[ch]--;
                if (remain[ch] <= 0) begin
                    pressed[ch] = ~pressed[ch];
                    remain[ch]  = $urandom_range(1, 14);
                end
            end
            ackv = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
            ackv = ackv | (m_pulse & NB'($urandom));
            if (cyc == 400) begin
                step(pressed, ackv, 1'b1);
                hold(1, pressed);
                rst_n = 1'b1;
            end else begin
                step(pressed, ackv, 1'b0);
            end
        end
        hold(3, '0);

        @(negedge sclk);
        #1;
        checks++;
        if (n_dut_pulses != n_model_pulses) begin
            errors++;
            $display("FAIL pulse_count got=%0d exp=%0d", n_dut_pulses, n_model_pulses);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_traffic_request_input
`default_nettype wire

// File: doc/traffic_request_input.md
Name: traffic_request_input

Overview:
- Input-side counterpart to the TrafficWing light sequencer: turns the four raw push-button pins into clean, latched crossing requests.
- Per button: 2-FF synchronizer, counter-based debouncer, press-edge detector and a sticky request flag.
- The light sequencer consumes each request with a one-cycle ack.
- Sits between the top-level button pins and the sequencer, clocked by the SB_HFOSC-derived sclk.

Parameters:
- N_BUTTONS, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 960000, consecutive cycles a new level must persist before it is accepted (20 ms at 48 MHz); legal minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width; derived, not overridden.
- BTN_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; internal logic is active-high after inversion.

Ports:
- sclk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_in  input  N_BUTTONS  raw, asynchronous button pins.
- ack  input  N_BUTTONS  one-cycle pulse from sequencer; clears the matching req bit.
- btn_level  output  N_BUTTONS  debounced level, 1 = pressed.
- press_pulse  output  N_BUTTONS  one-cycle pulse on each accepted press.
- req  output  N_BUTTONS  sticky pending request, held until acked.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - btn_level, press_pulse and req go to 0.
  - Synchronizer flops go to the "not pressed" value.
  - Debounce counters go to 0.
  - Applies mid-debounce and mid-request; any pending req is lost.
- Synchronizer: two flops per channel, with inversion applied when BTN_ACTIVE_LOW=1. The internal sample s is the second-flop output.
- Debounce, per channel:
  - If s == btn_level, counter <= 0.
  - If s != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= s and counter <= 0.
  - Otherwise counter <= counter+1.
  - Any glitch back to the stable level restarts the count.
- Latency: btn_in is first captured at edge 0, s changes after edge 1, and btn_level changes at edge 1+DEBOUNCE_CYCLES when the input stays constant.
- press_pulse:
  - Registered at the same edge btn_level goes 0->1.
  - High for exactly one cycle.
  - No pulse on release.
- req, per channel, registered:
  - If press_pulse=1, req <= 1. Press wins over a simultaneous ack.
  - Else if ack=1, req <= 0.
  - Else req holds.
  - req rises one edge after press_pulse.
  - ack while req=0 has no effect.
  - Repeated presses while req=1 keep it at 1; there is no counting.
- Channels are fully independent; simultaneous presses on several channels all latch.
- A counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Decomposition:
- Shared package traffic_pkg:
  - N_BUTTONS default.
  - Channel index constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3, shared with the light sequencer.
  - Default DEBOUNCE_CYCLES.
- Sub-module debounce_cell, one instance per channel via generate:
  - Contains synchronizer, counter, btn_level and press_pulse.
  - The req/ack latch stays in the top of traffic_request_input.

Test Plan (DEBOUNCE_CYCLES=8, BTN_ACTIVE_LOW=1 for simulation):
1. Reset, then btn_in[0] driven 0 and held -> btn_level[0]=1 at edge 9 after capture, press_pulse[0] high exactly 1 cycle at edge 9, req[0]=1 from edge 10; other channels stay 0.
2. btn_in[1] bounces low for 5 cycles, high 1 cycle, low 8 cycles -> no pulse during the first burst; btn_level[1] rises only after 8 consecutive pressed samples; exactly one press_pulse.
3. req[2]=1, ack[2] pulsed 1 cycle -> req[2]=0 next edge; later ack[2] pulse with req[2]=0 -> no change.
4. press_pulse[3] and ack[3] in the same cycle while req[3]=1 -> req[3] remains 1.
5. All four buttons pressed in the same cycle -> four simultaneous press_pulses and req=4'b1111; release of all -> btn_level=0 after 8+1 edges, no pulses, req stays 4'b1111.
6. rst_n asserted asynchronously mid-debounce (counter=5) with req=4'b0101 -> all outputs 0 immediately without a clock edge; after release, a held button needs the full 1+8 edges again.
